// File: rtl/partial_product_pkg.sv
`default_nettype none
// ============================================================================
// Module      : partial_product_pkg
// Description : Shared types and width helpers for the partial product
//               accumulator (state enum, input/output width functions).
// Revision    : 1.0 - initial release
// ============================================================================
package partial_product_pkg;

  // Accumulator control states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } ppa_state_e;

  // Width of one signed plane sum for serial length l (range -l..+l)
  function automatic int in_w(input int l);
    return $clog2(l) + 2;
  endfunction

  // Width of the combined result: one extra bit per bit-plane shift
  function automatic int out_w(input int l, input int w);
    return in_w(l) + w;
  endfunction

endpackage : partial_product_pkg
`default_nettype wire

// File: rtl/partial_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : partial_product_accumulator_if
// Description : Plane-sum input / result output bundle for the partial
//               product accumulator. master drives planes, slave is the block.
// Revision    : 1.0 - initial release
// ============================================================================
interface partial_product_accumulator_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);

  logic                    start;
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    busy;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output start,
    output in_valid,
    output in_data,
    input  busy,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    output busy,
    output out_valid,
    output out_data
  );

endinterface : partial_product_accumulator_if
`default_nettype wire

// File: rtl/ppa_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : ppa_shift_add
// Description : Combinational shift-accumulate step:
//               acc_next = (acc << 1) +/- sext(in_data).
// Revision    : 1.0 - initial release
// ============================================================================
module ppa_shift_add #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [OUT_W-1:0] acc,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    negate,
  output logic signed [OUT_W-1:0] acc_next
);

  logic signed [OUT_W-1:0] ext;
  logic signed [OUT_W-1:0] term;

  // Sign-extend the plane sum, optionally negate it, then fold into the doubled accumulator
  always_comb begin
    ext      = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
    term     = negate ? -ext : ext;
    acc_next = (acc << 1) + term;
  end

endmodule : ppa_shift_add
`default_nettype wire

// File: rtl/partial_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : partial_product_accumulator
// Description : Combines WEIGHT_BITS signed plane sums (MSB plane first) into
//               one dot-product result with a single-cycle valid pulse.
//               Macro PPA_SIGNED_WEIGHTS_EN: when defined the MSB plane carries
//               negative weight (two's-complement weights); when undefined all
//               planes are positive (unsigned weights).
// Revision    : 1.0 - initial release
// ============================================================================
module partial_product_accumulator
  import partial_product_pkg::*;
#(
  parameter int SERIAL_INPUT_LENGTH = 64,
  parameter int WEIGHT_BITS         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  partial_product_accumulator_if.slave  bus
);

  localparam int IN_W   = in_w(SERIAL_INPUT_LENGTH);
  localparam int OUT_W  = out_w(SERIAL_INPUT_LENGTH, WEIGHT_BITS);
  localparam int PCNT_W = $clog2(WEIGHT_BITS);
  localparam logic [PCNT_W-1:0] LAST_PLANE = PCNT_W'(WEIGHT_BITS - 1);

  ppa_state_e              state_q, state_d;
  logic [PCNT_W-1:0]       plane_cnt_q, plane_cnt_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;

  // A start pulse makes the current beat count as plane 0 on a cleared accumulator
  logic                    accept;
  logic [PCNT_W-1:0]       cnt_base;
  logic signed [OUT_W-1:0] acc_base;
  logic                    negate;
  logic signed [OUT_W-1:0] acc_next;

  assign accept   = bus.in_valid && ((state_q == ACCUM) || bus.start);
  assign cnt_base = bus.start ? '0 : plane_cnt_q;
  assign acc_base = bus.start ? '0 : acc_q;

`ifdef PPA_SIGNED_WEIGHTS_EN
  assign negate = (cnt_base == '0);
`else
  assign negate = 1'b0;
`endif

  ppa_shift_add #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_shift_add (
    .acc      (acc_base),
    .in_data  (bus.in_data),
    .negate   (negate),
    .acc_next (acc_next)
  );

  // Next-state, counter and result selection
  always_comb begin
    state_d     = state_q;
    plane_cnt_d = plane_cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    if (bus.start) begin
      state_d     = ACCUM;
      plane_cnt_d = '0;
      acc_d       = '0;
    end

    if (accept) begin
      if (cnt_base == LAST_PLANE) begin
        out_data_d  = acc_next;
        out_valid_d = 1'b1;
        acc_d       = '0;
        plane_cnt_d = '0;
        state_d     = IDLE;
      end else begin
        acc_d       = acc_next;
        plane_cnt_d = cnt_base + PCNT_W'(1);
      end
    end

    busy_d = (state_d == ACCUM);
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      plane_cnt_q <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      plane_cnt_q <= plane_cnt_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule : partial_product_accumulator
`default_nettype wire

// File: tb/tb_partial_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_partial_product_accumulator
// Description : Self-checking bench for partial_product_accumulator, L=64, W=4.
//               Expected results follow PPA_SIGNED_WEIGHTS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_partial_product_accumulator;
  import partial_product_pkg::*;

  localparam int L     = 64;
  localparam int W     = 4;
  localparam int IN_W  = in_w(L);
  localparam int OUT_W = out_w(L, W);

`ifdef PPA_SIGNED_WEIGHTS_EN
  localparam int E_BASIC   = -21;
  localparam int E_ALLPOS  = -64;
  localparam int E_MSBNEG  = 960;
  localparam int E_ONES    = -7;
`else
  localparam int E_BASIC   = 27;
  localparam int E_ALLPOS  = 960;
  localparam int E_MSBNEG  = -64;
  localparam int E_ONES    = 15;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  partial_product_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  partial_product_accumulator #(
    .SERIAL_INPUT_LENGTH (L),
    .WEIGHT_BITS         (W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: weighted sum of the collected plane values
  function automatic int plane_sum(input int b[W]);
    int sum = 0;
    for (int i = 0; i < W; i++) begin
      int wgt = 1 << (W - 1 - i);
`ifdef PPA_SIGNED_WEIGHTS_EN
      if (i == 0) wgt = -wgt;
`endif
      sum += wgt * b[i];
    end
    return sum;
  endfunction

  int beats[W];
  int m_cnt     = 0;
  bit m_open    = 0;
  bit exp_valid = 0;
  bit exp_busy  = 0;
  int exp_data  = 0;

  // Model: collect accepted planes, emit weighted sum once W have arrived
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 0; m_cnt = 0; exp_valid = 0; exp_busy = 0; exp_data = 0;
    end else begin
      exp_valid = 0;
      if (bus.start) begin
        m_open = 1;
        m_cnt  = 0;
      end
      if (bus.in_valid && m_open) begin
        beats[m_cnt] = int'(bus.in_data);
        m_cnt++;
        if (m_cnt == W) begin
          exp_data  = plane_sum(beats);
          exp_valid = 1;
          m_open    = 0;
          m_cnt     = 0;
        end
      end
      exp_busy = m_open;
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy",      int'(bus.busy),      int'(exp_busy));
      chk("out_valid", int'(bus.out_valid), int'(exp_valid));
      chk("out_data",  int'(bus.out_data),  exp_data);
      if (bus.out_valid) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit v, input int d);
    bus.start    = s;
    bus.in_valid = v;
    bus.in_data  = IN_W'(d);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    rst_n = 1'b1;
    tick();

    // Basic: separate start, then back-to-back planes
    drive(1, 0, 0);
    drive(0, 1, 3);
    drive(0, 1, -2);
    drive(0, 1, 5);
    drive(0, 1, 1);
    chk("basic_valid", int'(bus.out_valid), 1);
    chk("basic_data",  int'(bus.out_data),  E_BASIC);
    chk("basic_busy",  int'(bus.busy),      0);

    // Start coincides with the previous out_valid; all planes +64
    drive(1, 1, 64);
    repeat (3) drive(0, 1, 64);
    chk("allpos_data", int'(bus.out_data), E_ALLPOS);

    // MSB -64, others +64
    drive(1, 1, -64);
    repeat (3) drive(0, 1, 64);
    chk("msbneg_data", int'(bus.out_data), E_MSBNEG);

    // Start with first beat, then idle gaps of 2, 3, 0 cycles
    drive(1, 1, 3);
    repeat (2) begin
      chk("gap_busy", int'(bus.busy), 1);
      tick();
    end
    drive(0, 1, -2);
    repeat (3) begin
      chk("gap_busy", int'(bus.busy), 1);
      tick();
    end
    drive(0, 1, 5);
    chk("gap_no_early_valid", int'(bus.out_valid), 0);
    drive(0, 1, 1);
    chk("gap_valid", int'(bus.out_valid), 1);
    chk("gap_data",  int'(bus.out_data),  E_BASIC);

    // Abort mid-operation then restart with 1,1,1,1
    tick();
    pulses = 0;
    drive(1, 0, 0);
    drive(0, 1, 3);
    drive(0, 1, -2);
    drive(1, 0, 0);
    chk("abort_hold_data", int'(bus.out_data), E_BASIC);
    repeat (4) drive(0, 1, 1);
    chk("abort_data", int'(bus.out_data), E_ONES);
    tick();
    tick();
    chk("abort_pulses", pulses, 1);

    // Asynchronous reset after the 2nd plane
    drive(1, 0, 0);
    drive(0, 1, 3);
    drive(0, 1, -2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy",      int'(bus.busy),      0);
    chk("async_out_valid", int'(bus.out_valid), 0);
    chk("async_out_data",  int'(bus.out_data),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // in_valid in IDLE without start is ignored
    pulses       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(5);
    repeat (3) begin
      tick();
      chk("idle_busy",      int'(bus.busy),      0);
      chk("idle_out_valid", int'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("idle_pulses", pulses, 0);

    // Normal operation still works after reset
    drive(1, 1, 1);
    repeat (3) drive(0, 1, 1);
    chk("post_rst_data", int'(bus.out_data), E_ONES);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_partial_product_accumulator
`default_nettype wire

// File: doc/partial_product_accumulator.md
# partial_product_accumulator

Bit-plane shift-accumulate stage directly downstream of the serial thermometer counter. Each weight bit-plane produces one signed partial sum, offset-corrected into two's complement (range −L..+L). This block consumes one such sum per plane, MSB plane first, and combines WEIGHT_BITS planes into one signed dot-product result. It emits a single-cycle valid pulse with that result.

## Interface
- SERIAL_INPUT_LENGTH, 64: L, the serial input length of the upstream counter; sets the input range −L..+L.
- WEIGHT_BITS, 8: W, the number of bit-planes per result; must be ≥2.
- Derived: IN_W = $clog2(L)+2 (matches the upstream final output width); OUT_W = IN_W+W; PCNT_W = $clog2(W).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that opens a new accumulation; it aborts any operation in progress.
- in_valid  input  1  in_data holds a plane sum this cycle.
- in_data  input  IN_W  signed plane sum, two's complement.
- busy  output  1  high while an accumulation is open.
- out_valid  output  1  one-cycle pulse when a result is ready.
- out_data  output  OUT_W  signed result; holds its value until the next result.

## Operation
- FSM states: IDLE and ACCUM.
- IDLE → ACCUM on start.
- ACCUM → IDLE on the accepted beat with plane_cnt==W−1.
- ACCUM → ACCUM on start (restart).
- A beat is accepted when in_valid=1 and (state==ACCUM or start=1).
- in_valid in IDLE without start is ignored; no state changes.
- On start: plane_cnt←0 and acc←0. If in_valid is also high, that beat is accepted as plane 0 using acc=0.
- Per accepted beat: acc_next = (acc<<1) + term, computed in OUT_W bits.
  - term = −sext(in_data) when plane_cnt==0 (MSB plane, negative weight).
  - term = +sext(in_data) otherwise.
  - plane_cnt is then incremented.
- Last beat (plane_cnt==W−1): out_data←acc_next, out_valid←1, acc←0, plane_cnt←0, state←IDLE.
- Overflow is impossible: |result| ≤ L·2^W < 2^(OUT_W−1). No saturation logic exists.
- Abort by start mid-operation: the partial acc is discarded, out_valid is not pulsed, and out_data is unchanged.

## Timing
- Reset values: state=IDLE, busy=0, out_valid=0, out_data=0, acc=0, plane_cnt=0.
- busy is registered: it rises the cycle after start and falls the cycle after the last beat is accepted.
- Latency: out_valid is asserted in the cycle after the W-th accepted beat.
- Back-to-back operation: start may coincide with the cycle in which out_valid is high. The new operation is unaffected.
- in_valid gaps inside ACCUM are allowed; the accumulator simply holds.
- Reset is asynchronous and active-low. Asserting rst_n mid-operation returns all state to reset values immediately, with no output pulse.

## Configuration
- PPA_SIGNED_WEIGHTS_EN
  - Defined: the MSB plane term is negated, as described above, giving two's-complement weights.
  - Undefined: every plane term is +sext(in_data), giving unsigned weights. The bound becomes |result| ≤ L·(2^W−1), which still fits OUT_W.
- The macro affects only the sign-selection mux of the term.

## Structure
- Shared package partial_product_pkg holds:
  - the state enum {IDLE, ACCUM};
  - width functions in_w(L) and out_w(L,W).
- One natural sub-module, ppa_shift_add: combinational acc_next = (acc<<1) ± sext(in_data), with a negate-select input.
- FSM, counter and registers stay in the top.

## Test plan
- L=64, W=4, signed: start, then beats 3, −2, 5, 1 → one out_valid pulse with out_data=−21 (3·(−8)−2·4+5·2+1).
- Same stimulus with PPA_SIGNED_WEIGHTS_EN undefined → out_data=27.
- Extremes, signed, W=4:
  - all planes +64 → −64;
  - MSB −64, others +64 → +960;
  - no wrap in either case.
- start together with the first in_valid, then gaps of 0–3 idle cycles between beats → same −21. out_valid arrives exactly 1 cycle after the 4th beat; busy is high throughout.
- Abort: start, beats 3, −2, then start again, then 1, 1, 1, 1 → the only out_valid carries −7 (−8+4+2+1). The earlier partial produces no pulse.
- rst_n asserted asynchronously after the 2nd beat → all outputs 0 immediately. in_valid in IDLE without start is then ignored: busy stays 0 and no out_valid.
